// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the lab ALU datapath blocks.
//   - DEFAULT_WIDTH : default operand width of the divide path
//   - state_t       : sequential divider state encoding (IDLE/RUN/DONE)
// ---------------------------------------------------------------------------
package alu_pkg;

    localparam int DEFAULT_WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

endpackage : alu_pkg

// File: rtl/addsub_w.sv
// ---------------------------------------------------------------------------
// addsub_w
// Parameterised ripple-carry adder/subtractor.
// cin doubles as the subtract select: when 1 the b operand is inverted and
// the carry-in of 1 completes the two's complement, giving a - b.
// Ports:
//   a    in  W  first operand
//   b    in  W  second operand
//   cin  in  1  carry-in / subtract select
//   sum  out W  result
//   cout out 1  carry-out (1 = no borrow when subtracting)
// ---------------------------------------------------------------------------
module addsub_w #(
    parameter int W = 5
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] sum,
    output logic         cout
);

    // Bit-serial carry ripple from LSB to MSB.
    always_comb begin
        logic carry;
        logic bx;
        carry = cin;
        sum   = {W{1'b0}};
        for (int i = 0; i < W; i++) begin
            bx     = b[i] ^ cin;
            sum[i] = a[i] ^ bx ^ carry;
            carry  = (a[i] & bx) | (a[i] & carry) | (bx & carry);
        end
        cout = carry;
    end

endmodule : addsub_w

// File: rtl/div_seq.sv
// ---------------------------------------------------------------------------
// div_seq
// Sequential restoring divider for unsigned WIDTH-bit operands, producing one
// quotient bit per clock through a single (WIDTH+1)-bit subtract stage.
// Ports:
//   clk          in  1      rising-edge clock
//   rst_n        in  1      asynchronous active-low reset
//   start        in  1      request, accepted only in IDLE or DONE
//   dividend     in  WIDTH  unsigned dividend, captured on accepted start
//   divisor      in  WIDTH  unsigned divisor, captured on accepted start
//   busy         out 1      high while iterating (state RUN)
//   done         out 1      one-cycle pulse, results valid from this cycle
//   quotient     out WIDTH  registered quotient
//   remainder    out WIDTH  registered remainder
//   div_by_zero  out 1      registered zero-divisor flag for the last result
// ---------------------------------------------------------------------------
module div_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    state_t             state_q,     state_d;
    logic [WIDTH:0]     a_q,         a_d;
    logic [WIDTH-1:0]   q_q,         q_d;
    logic [WIDTH:0]     d_q,         d_d;
    logic [CNT_W-1:0]   cnt_q,       cnt_d;
    logic               busy_q,      busy_d;
    logic               done_q,      done_d;
    logic [WIDTH-1:0]   quotient_q,  quotient_d;
    logic [WIDTH-1:0]   remainder_q, remainder_d;
    logic               dbz_q,       dbz_d;

    logic [WIDTH:0]     a_shift_s;
    logic [WIDTH:0]     trial_s;
    logic               no_borrow_s;
    logic [WIDTH:0]     a_next_s;
    logic [WIDTH-1:0]   q_next_s;

    // {A,Q} shifted left: the MSB of Q moves into the LSB of A.
    assign a_shift_s = {a_q[WIDTH-1:0], q_q[WIDTH-1]};

    addsub_w #(
        .W (WIDTH + 1)
    ) u_addsub (
        .a    (a_shift_s),
        .b    (d_q),
        .cin  (1'b1),
        .sum  (trial_s),
        .cout (no_borrow_s)
    );

    // Restore step: keep the shifted A when the trial subtraction borrowed.
    assign a_next_s = no_borrow_s ? trial_s : a_shift_s;
    assign q_next_s = {q_q[WIDTH-2:0], no_borrow_s};

    // Next-state, datapath and output-register computation.
    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        q_d         = q_q;
        d_d         = d_q;
        cnt_d       = cnt_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        dbz_d       = dbz_q;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    if (divisor != {WIDTH{1'b0}}) begin
                        a_d     = {(WIDTH + 1){1'b0}};
                        q_d     = dividend;
                        d_d     = {1'b0, divisor};
                        cnt_d   = CNT_W'(WIDTH);
                        state_d = RUN;
                    end else begin
                        // Zero divisor bypasses iteration entirely.
                        quotient_d  = {WIDTH{1'b1}};
                        remainder_d = dividend;
                        dbz_d       = 1'b1;
                        state_d     = DONE;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                a_d   = a_next_s;
                q_d   = q_next_s;
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    quotient_d  = q_next_s;
                    remainder_d = a_next_s[WIDTH-1:0];
                    dbz_d       = 1'b0;
                    state_d     = DONE;
                end else begin
                    state_d = RUN;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Status flags are registered copies of the next state.
        busy_d = (state_d == RUN);
        done_d = (state_d == DONE);
    end

    // State, datapath and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            a_q         <= {(WIDTH + 1){1'b0}};
            q_q         <= {WIDTH{1'b0}};
            d_q         <= {(WIDTH + 1){1'b0}};
            cnt_q       <= {CNT_W{1'b0}};
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            quotient_q  <= {WIDTH{1'b0}};
            remainder_q <= {WIDTH{1'b0}};
            dbz_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            q_q         <= q_d;
            d_q         <= d_d;
            cnt_q       <= cnt_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            dbz_q       <= dbz_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign div_by_zero = dbz_q;

endmodule : div_seq
